// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: column/row counters with porch/sync
// decode, gated by a pixel-clock enable. Every output is registered.
module vga_timing_gen #(
    parameter int   c_H_VISIBLE  = 640,
    parameter int   c_H_FRONT    = 16,
    parameter int   c_H_SYNC     = 96,
    parameter int   c_H_BACK     = 48,
    parameter int   c_V_VISIBLE  = 480,
    parameter int   c_V_FRONT    = 10,
    parameter int   c_V_SYNC     = 2,
    parameter int   c_V_BACK     = 33,
    parameter logic c_H_SYNC_POL = 1'b0,
    parameter logic c_V_SYNC_POL = 1'b0,
    parameter int   c_CNT_W      = 10
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Enable,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic               o_Active,
    output logic [c_CNT_W-1:0] o_ColCount,
    output logic [c_CNT_W-1:0] o_RowCount,
    output logic               o_LineStart,
    output logic               o_FrameStart
);

    localparam int H_TOTAL = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int V_TOTAL = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    localparam logic [c_CNT_W-1:0] H_VIS     = c_CNT_W'(c_H_VISIBLE);
    localparam logic [c_CNT_W-1:0] H_SYNC_LO = c_CNT_W'(c_H_VISIBLE + c_H_FRONT);
    localparam logic [c_CNT_W-1:0] H_SYNC_HI = c_CNT_W'(c_H_VISIBLE + c_H_FRONT + c_H_SYNC);
    localparam logic [c_CNT_W-1:0] H_LAST    = c_CNT_W'(H_TOTAL - 1);
    localparam logic [c_CNT_W-1:0] V_VIS     = c_CNT_W'(c_V_VISIBLE);
    localparam logic [c_CNT_W-1:0] V_SYNC_LO = c_CNT_W'(c_V_VISIBLE + c_V_FRONT);
    localparam logic [c_CNT_W-1:0] V_SYNC_HI = c_CNT_W'(c_V_VISIBLE + c_V_FRONT + c_V_SYNC);
    localparam logic [c_CNT_W-1:0] V_LAST    = c_CNT_W'(V_TOTAL - 1);
    localparam logic [c_CNT_W-1:0] CNT_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [c_CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               active_q, active_d;
    logic               line_start_q, line_start_d, frame_start_q, frame_start_d;

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        col_d         = col_q;
        row_d         = row_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (i_Enable) begin
            // Outputs present the position the counters held before this tick.
            col_d         = h_q;
            row_d         = v_q;
            active_d      = (h_q < H_VIS) && (v_q < V_VIS);
            hsync_d       = ((h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI)) ? c_H_SYNC_POL : ~c_H_SYNC_POL;
            vsync_d       = ((v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI)) ? c_V_SYNC_POL : ~c_V_SYNC_POL;
            line_start_d  = (h_q == '0);
            frame_start_d = (h_q == '0) && (v_q == '0);
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_ONE;
            end else begin
                h_d = h_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            h_q           <= '0;
            v_q           <= '0;
            col_q         <= '0;
            row_q         <= '0;
            hsync_q       <= ~c_H_SYNC_POL;
            vsync_q       <= ~c_V_SYNC_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_HSync      = hsync_q;
    assign o_VSync      = vsync_q;
    assign o_Active     = active_q;
    assign o_ColCount   = col_q;
    assign o_RowCount   = row_q;
    assign o_LineStart  = line_start_q;
    assign o_FrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-parameter instance driven from a vector
// table plus frame loops, and a default 640x480 instance over its first lines.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en  = 1'b0;

    logic       d_hs, d_vs, d_act, d_ls, d_fs;
    logic [9:0] d_col, d_row;
    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [3:0] s_col, s_row;

    vga_timing_gen dut_def (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
        .o_HSync(d_hs), .o_VSync(d_vs), .o_Active(d_act),
        .o_ColCount(d_col), .o_RowCount(d_row),
        .o_LineStart(d_ls), .o_FrameStart(d_fs)
    );

    vga_timing_gen #(
        .c_H_VISIBLE(4), .c_H_FRONT(1), .c_H_SYNC(2), .c_H_BACK(1),
        .c_V_VISIBLE(3), .c_V_FRONT(1), .c_V_SYNC(1), .c_V_BACK(1),
        .c_H_SYNC_POL(1'b1), .c_V_SYNC_POL(1'b1), .c_CNT_W(4)
    ) dut_sml (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
        .o_HSync(s_hs), .o_VSync(s_vs), .o_Active(s_act),
        .o_ColCount(s_col), .o_RowCount(s_row),
        .o_LineStart(s_ls), .o_FrameStart(s_fs)
    );

    typedef struct {
        logic rst;
        logic en;
        int   col;
        int   row;
        logic act;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t tbl[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_def(input int col, input int row, input bit strobes);
        chk("def_col", 32'(d_col), col);
        chk("def_row", 32'(d_row), row);
        chk("def_act", 32'(d_act), 32'(col < 640 && row < 480));
        chk("def_hs",  32'(d_hs),  32'(!(col >= 656 && col < 752)));
        chk("def_vs",  32'(d_vs),  32'(!(row >= 490 && row < 492)));
        chk("def_ls",  32'(d_ls),  32'(strobes && col == 0));
        chk("def_fs",  32'(d_fs),  32'(strobes && col == 0 && row == 0));
    endtask

    task automatic chk_sml(input int col, input int row, input logic act, input logic hs,
                           input logic vs, input logic ls, input logic fs);
        chk("sml_col", 32'(s_col), col);
        chk("sml_row", 32'(s_row), row);
        chk("sml_act", 32'(s_act), 32'(act));
        chk("sml_hs",  32'(s_hs),  32'(hs));
        chk("sml_vs",  32'(s_vs),  32'(vs));
        chk("sml_ls",  32'(s_ls),  32'(ls));
        chk("sml_fs",  32'(s_fs),  32'(fs));
    endtask

    initial begin
        int hs_low;
        int act_cnt;
        int fs_cnt;
        int c;

        //                rst en col row act hs vs ls fs
        tbl[0]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].rst, tbl[i].en);
            chk_sml(tbl[i].col, tbl[i].row, tbl[i].act, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs);
        end

        // Two full small frames, including the simultaneous h/v wrap.
        act_cnt = 1;
        fs_cnt  = 0;
        for (int k = 1; k <= 96; k++) begin
            int col;
            int row;
            tick(1'b0, 1'b1);
            col = k % 8;
            row = (k / 8) % 6;
            chk_sml(col, row, (col < 4 && row < 3), (col >= 5 && col < 7), (row == 4),
                    (col == 0), (k % 48 == 0));
            if (k < 48 && s_act) act_cnt++;
            if (s_fs) fs_cnt++;
        end
        chk("sml_active_per_frame", act_cnt, 12);
        chk("sml_frame_starts", fs_cnt, 2);

        // Default instance: reset state, then the first two lines and part of a third.
        tick(1'b1, 1'b1);
        chk("def_rst_col", 32'(d_col), 0);
        chk("def_rst_row", 32'(d_row), 0);
        chk("def_rst_act", 32'(d_act), 0);
        chk("def_rst_hs",  32'(d_hs), 1);
        chk("def_rst_vs",  32'(d_vs), 1);
        chk("def_rst_ls",  32'(d_ls), 0);
        chk("def_rst_fs",  32'(d_fs), 0);

        hs_low = 0;
        for (int k = 0; k < 2 * 800 + 300; k++) begin
            tick(1'b0, 1'b1);
            chk_def(k % 800, k / 800, 1'b1);
            if (k < 800 && !d_hs) hs_low++;
        end
        chk("def_hsync_low_clocks", hs_low, 96);

        // Enable held low mid-line: everything frozen, then resume with no skip.
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 1'b0);
            chk_def(299, 2, 1'b0);
        end
        tick(1'b0, 1'b1);
        chk_def(300, 2, 1'b1);

        // Reset mid-frame aborts on that edge; restart is clean.
        tick(1'b1, 1'b1);
        chk("def_abort_col", 32'(d_col), 0);
        chk("def_abort_act", 32'(d_act), 0);
        chk("def_abort_hs",  32'(d_hs), 1);
        chk("def_abort_ls",  32'(d_ls), 0);
        chk("def_abort_fs",  32'(d_fs), 0);
        tick(1'b0, 1'b0);
        chk("def_idle_fs", 32'(d_fs), 0);
        chk("def_idle_col", 32'(d_col), 0);
        tick(1'b0, 1'b1);
        chk_def(0, 0, 1'b1);

        // Toggling enable: counters advance only on enabled clocks.
        c = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                tick(1'b0, 1'b1);
                c++;
                chk_def(c, 0, 1'b1);
            end else begin
                tick(1'b0, 1'b0);
                chk_def(c, 0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed visible/blank sync generator with full porch/sync/back-porch timing, programmable sync polarity, a pixel-clock enable, an active-video flag and line/frame start strobes. It sits between the pixel clock domain and every raster consumer (pattern generators, pong renderer, sync-delay pipelines). All consumers see counters and flags aligned on the same clock edge.

## Interface
- c_H_VISIBLE, 640, visible pixels per line
- c_H_FRONT, 16, horizontal front porch (pixels)
- c_H_SYNC, 96, horizontal sync width (pixels)
- c_H_BACK, 48, horizontal back porch (pixels)
- c_V_VISIBLE, 480, visible lines per frame
- c_V_FRONT, 10, vertical front porch (lines)
- c_V_SYNC, 2, vertical sync width (lines)
- c_V_BACK, 33, vertical back porch (lines)
- c_H_SYNC_POL, 0, asserted level of o_HSync (0 = active-low)
- c_V_SYNC_POL, 0, asserted level of o_VSync
- c_CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Enable  in  1  pixel tick; the raster advances only on cycles where it is 1
- o_HSync  out  1  horizontal sync at c_H_SYNC_POL level when asserted
- o_VSync  out  1  vertical sync at c_V_SYNC_POL level when asserted
- o_Active  out  1  1 when the current pixel is visible
- o_ColCount  out  c_CNT_W  current column
- o_RowCount  out  c_CNT_W  current row
- o_LineStart  out  1  one-clock strobe at column 0
- o_FrameStart  out  1  one-clock strobe at column 0, row 0

## Operation
- H_TOTAL = sum of the four H params (800 by default). V_TOTAL = sum of the four V params (525 by default).
- Internal state: column counter h and row counter v.
- On an enable cycle:
  - outputs capture the decode of the current (h, v);
  - h increments and wraps H_TOTAL-1 -> 0;
  - on the h wrap, v increments and wraps V_TOTAL-1 -> 0.
- Decode:
  - Active = (h < H_VISIBLE) and (v < V_VISIBLE);
  - HSync asserted when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC;
  - VSync asserted when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC;
  - LineStart = (h == 0); FrameStart = (h == 0 and v == 0).
- VSync therefore toggles coincident with column 0 of a row.
- On a non-enable cycle:
  - counters, o_ColCount, o_RowCount, o_HSync, o_VSync and o_Active hold;
  - o_LineStart and o_FrameStart go to 0.
- Strobes are therefore exactly one i_Clk wide, regardless of the enable duty cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Timing
- Reset state (on any i_Clk edge with i_Reset = 1, regardless of i_Enable):
  - h = v = 0; o_ColCount = o_RowCount = 0;
  - o_Active = 0; o_LineStart = o_FrameStart = 0;
  - o_HSync = ~c_H_SYNC_POL; o_VSync = ~c_V_SYNC_POL.
- Latency: one enabled cycle from internal state to outputs.
  - The first enabled cycle after reset release presents col 0, row 0, o_Active = 1, o_LineStart = 1, o_FrameStart = 1.
- Frame period is H_TOTAL × V_TOTAL enabled cycles. A frame with i_Enable held 1 is 420000 clocks by default.
- Reset asserted mid-frame:
  - aborts immediately on that edge;
  - no residual strobe;
  - the next frame starts cleanly at (0, 0).
- Simultaneous h wrap and v wrap: the next output is (0, 0) with both strobes high.
- Counters never exceed TOTAL-1, and no out-of-range value is ever presented.

## Test plan
- Defaults, i_Enable = 1, reset released: cycle 1 shows (0,0), Active = 1, FrameStart = 1. o_HSync is low for exactly 96 clocks, at cols 656–751 of every line. o_VSync is low for rows 490–491 (1600 clocks). FrameStart recurs every 420000 clocks.
- Defaults, i_Enable toggling 1/0: counters step every other clock. Strobes are 1 clock wide. Frame period is 840000 clocks.
- Small params H = 4/1/2/1, V = 3/1/1/1, polarities = 1:
  - H_TOTAL 8, V_TOTAL 6;
  - HSync high at cols 5–6; VSync high on row 4;
  - Active for 12 of 48 pixels per frame; FrameStart every 48 enabled cycles.
- Reset pulsed at col 300, row 200: on the next edge all outputs are at reset values. After release, the first enabled cycle gives (0,0) with FrameStart = 1.
- Line/frame wrap: at col 799 row 524, the next enabled output is (0,0) with LineStart = FrameStart = 1. At col 799 row 100, the next is (0,101) with only LineStart.
- Enable held 0 for 50 clocks mid-line: all outputs frozen (strobes 0). The raster resumes at the next column with no skip.
